// File: rtl/line_mem_responder_pkg.sv
// Shared definitions for the line memory responder and the cache above it.
// Address split, widths and read FSM state encoding.
package line_mem_responder_pkg;

   localparam int ADDR_W     = 13;
   localparam int LINE_W     = 32;
   localparam int WORD_IDX_W = 11;
   localparam int BYTE_OFF_W = 2;

   localparam int TAG_MSB = 12;
   localparam int TAG_LSB = 8;
   localparam int IDX_MSB = 7;
   localparam int IDX_LSB = 2;
   localparam int OFF_MSB = 1;
   localparam int OFF_LSB = 0;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_RESP = 2'd2,
      ST_HOLD = 2'd3
   } rsp_state_e;

   function automatic logic [WORD_IDX_W-1:0] word_idx(
      input logic [ADDR_W-1:0] a
   );
      return a[ADDR_W-1:BYTE_OFF_W];
   endfunction

endpackage

// File: rtl/line_mem_array.sv
// 2048x32 word store with byte write enables and one registered read port.
// Contents survive reset; only the read register is cleared.
module line_mem_array
   import line_mem_responder_pkg::*;
#(
   parameter string INIT_FILE = ""
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  re_i,
   input  logic [WORD_IDX_W-1:0] ridx_i,
   output logic [LINE_W-1:0]     rdata_o,
   input  logic                  we_i,
   input  logic [WORD_IDX_W-1:0] widx_i,
   input  logic [3:0]            wbe_i,
   input  logic [LINE_W-1:0]     wdata_i
);

   logic [LINE_W-1:0] mem_q [2**WORD_IDX_W];
   logic [LINE_W-1:0] rdata_q;

   initial begin
      for (int i = 0; i < 2**WORD_IDX_W; i++) begin
         mem_q[i] = '0;
      end
   end

   always_ff @(posedge clk) begin
      for (int b = 0; b < 4; b++) begin
         if (we_i && wbe_i[b]) begin
            mem_q[widx_i][8*b +: 8] <= wdata_i[8*b +: 8];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata_q <= '0;
      end else if (re_i) begin
         rdata_q <= mem_q[ridx_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/line_mem_responder.sv
// Main-memory responder: delayed line refills and write-through byte writes.
// A write landing on the capture edge is merged into the returned line.
module line_mem_responder
   import line_mem_responder_pkg::*;
#(
   parameter int    READ_LATENCY = 4,
   parameter string INIT_FILE    = ""
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              rreq_from_cache,
   input  logic [ADDR_W-1:0] raddr_from_cache,
   output logic [LINE_W-1:0] rdata_to_cache,
   output logic              rvalid_to_cache,
   input  logic              wreq_from_cache,
   input  logic [ADDR_W-1:0] waddr_from_cache,
   input  logic [7:0]        wdata_from_cache,
   output logic [15:0]       rd_count,
   output logic [15:0]       wr_count
);

   if ((READ_LATENCY < 1) || (READ_LATENCY > 15)) begin : g_bad_lat
      $error("READ_LATENCY must be within 1..15");
   end

   localparam logic [3:0] LAT_M1 = 4'(READ_LATENCY - 1);

   rsp_state_e            state_q, state_d;
   logic [3:0]            cnt_q, cnt_d;
   logic [WORD_IDX_W-1:0] ridx_q, ridx_d;
   logic                  rvalid_q, rvalid_d;
   logic [15:0]           rdcnt_q, rdcnt_d;
   logic [15:0]           wrcnt_q, wrcnt_d;
   logic                  mhit_q, mhit_d;
   logic [1:0]            moff_q, moff_d;
   logic [7:0]            mbyte_q, mbyte_d;
   logic                  capture;
   logic [LINE_W-1:0]     arr_rdata;
   logic [1:0]            unused_raddr_lo;

   assign unused_raddr_lo = raddr_from_cache[1:0];
   assign capture = (state_q == ST_BUSY) && (cnt_q == 4'd0);

   line_mem_array #(
      .INIT_FILE(INIT_FILE)
   ) u_array (
      .clk    (clk),
      .rst_n  (reset),
      .re_i   (capture),
      .ridx_i (ridx_q),
      .rdata_o(arr_rdata),
      .we_i   (wreq_from_cache),
      .widx_i (word_idx(waddr_from_cache)),
      .wbe_i  (4'b0001 << waddr_from_cache[1:0]),
      .wdata_i({4{wdata_from_cache}})
   );

   // Read FSM, write counter and capture-edge merge bookkeeping.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      ridx_d   = ridx_q;
      rvalid_d = 1'b0;
      rdcnt_d  = rdcnt_q;
      mhit_d   = mhit_q;
      moff_d   = moff_q;
      mbyte_d  = mbyte_q;
      wrcnt_d  = wrcnt_q + {15'd0, wreq_from_cache};
      unique case (state_q)
         ST_IDLE: begin
            if (rreq_from_cache) begin
               ridx_d  = word_idx(raddr_from_cache);
               cnt_d   = LAT_M1;
               state_d = ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               state_d  = ST_RESP;
               rvalid_d = 1'b1;
               mhit_d   = wreq_from_cache &&
                          (word_idx(waddr_from_cache) == ridx_q);
               moff_d   = waddr_from_cache[1:0];
               mbyte_d  = wdata_from_cache;
            end
         end
         ST_RESP: begin
            rdcnt_d = rdcnt_q + 16'd1;
            state_d = rreq_from_cache ? ST_HOLD : ST_IDLE;
         end
         ST_HOLD: begin
            if (!rreq_from_cache) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and statistics registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         ridx_q   <= '0;
         rvalid_q <= 1'b0;
         rdcnt_q  <= '0;
         wrcnt_q  <= '0;
         mhit_q   <= 1'b0;
         moff_q   <= '0;
         mbyte_q  <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         ridx_q   <= ridx_d;
         rvalid_q <= rvalid_d;
         rdcnt_q  <= rdcnt_d;
         wrcnt_q  <= wrcnt_d;
         mhit_q   <= mhit_d;
         moff_q   <= moff_d;
         mbyte_q  <= mbyte_d;
      end
   end

   // Returned line: array word with the capture-edge byte patched in.
   always_comb begin
      rdata_to_cache = arr_rdata;
      if (mhit_q) begin
         rdata_to_cache[8*moff_q +: 8] = mbyte_q;
      end
   end

   assign rvalid_to_cache = rvalid_q;
   assign rd_count        = rdcnt_q;
   assign wr_count        = wrcnt_q;

endmodule

// File: tb/tb_line_mem_responder.sv
// Bench for line_mem_responder: latency 4 and latency 1 instances share
// the write bus; each has its own read request lines.
module tb_line_mem_responder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        rreq  [2];
   logic [12:0] raddr [2];
   logic [31:0] rdata [2];
   logic        rvalid[2];
   logic [15:0] rdcnt [2];
   logic [15:0] wrcnt [2];
   logic        wreq;
   logic [12:0] waddr;
   logic [7:0]  wdata;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   line_mem_responder #(.READ_LATENCY(4), .INIT_FILE("")) u_dut4 (
      .clk(clk), .reset(rst_n),
      .rreq_from_cache(rreq[0]), .raddr_from_cache(raddr[0]),
      .rdata_to_cache(rdata[0]), .rvalid_to_cache(rvalid[0]),
      .wreq_from_cache(wreq), .waddr_from_cache(waddr),
      .wdata_from_cache(wdata),
      .rd_count(rdcnt[0]), .wr_count(wrcnt[0])
   );

   line_mem_responder #(.READ_LATENCY(1), .INIT_FILE("")) u_dut1 (
      .clk(clk), .reset(rst_n),
      .rreq_from_cache(rreq[1]), .raddr_from_cache(raddr[1]),
      .rdata_to_cache(rdata[1]), .rvalid_to_cache(rvalid[1]),
      .wreq_from_cache(wreq), .waddr_from_cache(waddr),
      .wdata_from_cache(wdata),
      .rd_count(rdcnt[1]), .wr_count(wrcnt[1])
   );

   // ---------------- behavioural model ----------------
   logic [7:0]  m [8192] = '{default: 8'h00};
   int          n_edge = 0;
   bit          pend [2] = '{0, 0};
   bit          blk  [2] = '{0, 0};
   bit          rlast[2] = '{0, 0};
   int          due  [2] = '{0, 0};
   logic [10:0] idx  [2] = '{11'd0, 11'd0};
   logic [31:0] e_data[2] = '{32'd0, 32'd0};
   bit          e_val [2] = '{0, 0};
   logic [15:0] e_rd  [2] = '{16'd0, 16'd0};
   logic [15:0] e_wr  [2] = '{16'd0, 16'd0};
   bit          wp, wb;

   function automatic int lat_of(input int i);
      return (i == 0) ? 4 : 1;
   endfunction

   function automatic logic [31:0] word(input logic [10:0] x);
      return {m[{x, 2'd3}], m[{x, 2'd2}], m[{x, 2'd1}], m[{x, 2'd0}]};
   endfunction

   // Response lands exactly lat edges after acceptance; a new request is
   // accepted only after rreq has been seen low following the response.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            pend[i] = 0; blk[i] = 0; rlast[i] = 0;
            e_data[i] = '0; e_val[i] = 0;
            e_rd[i] = '0; e_wr[i] = '0;
         end
      end else begin
         n_edge++;
         if (wreq) begin
            m[waddr] = wdata;
            for (int i = 0; i < 2; i++) e_wr[i] = e_wr[i] + 16'd1;
         end
         for (int i = 0; i < 2; i++) begin
            wp = pend[i];
            wb = blk[i];
            e_val[i] = 0;
            if (rlast[i]) begin
               e_rd[i] = e_rd[i] + 16'd1;
               rlast[i] = 0;
            end
            if (wb && !rreq[i]) blk[i] = 0;
            if (!wp && !wb && rreq[i]) begin
               pend[i] = 1;
               due[i]  = n_edge + lat_of(i);
               idx[i]  = raddr[i][12:2];
            end
            if (wp && n_edge == due[i]) begin
               e_data[i] = word(idx[i]);
               e_val[i]  = 1;
               pend[i]   = 0;
               blk[i]    = 1;
               rlast[i]  = 1;
            end
         end
      end
   end

   // ---------------- helpers ----------------
   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic wr(input logic [12:0] a, input logic [7:0] d);
      wreq = 1'b1; waddr = a; wdata = d;
      @(negedge clk);
      wreq = 1'b0;
   endtask

   task automatic wait_resp(input int i, output logic [31:0] d,
                            output int lat);
      int  k;
      bit  got;
      k = 0; got = 0;
      while (!got && k < 40) begin
         @(posedge clk);
         k++;
         @(negedge clk);
         if (k == 1) raddr[i] = 13'h1555;
         if (rvalid[i]) got = 1;
      end
      chk($sformatf("rvalid_seen%0d", i), {31'd0, got}, 32'd1);
      d   = rdata[i];
      lat = k - 1;
   endtask

   task automatic rd(input int i, input logic [12:0] a, input int hold,
                     output logic [31:0] d, output int lat,
                     output int extra);
      rreq[i] = 1'b1; raddr[i] = a;
      extra = 0;
      wait_resp(i, d, lat);
      repeat (hold) begin
         @(negedge clk);
         if (rvalid[i]) extra++;
      end
      rreq[i] = 1'b0;
      @(negedge clk);
   endtask

   // ---------------- stimulus and checking ----------------
   initial begin
      logic [31:0] d;
      int          lat, ex;
      rreq[0] = 0; rreq[1] = 0;
      raddr[0] = '0; raddr[1] = '0;
      wreq = 0; waddr = '0; wdata = '0;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;

      fork
         forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
               chk($sformatf("rvalid%0d", i), {31'd0, rvalid[i]},
                   {31'd0, e_val[i]});
               chk($sformatf("rdata%0d", i), rdata[i], e_data[i]);
               chk($sformatf("rd_count%0d", i), {16'd0, rdcnt[i]},
                   {16'd0, e_rd[i]});
               chk($sformatf("wr_count%0d", i), {16'd0, wrcnt[i]},
                   {16'd0, e_wr[i]});
            end
         end
      join_none

      repeat (3) @(negedge clk);
      chk("reset_rvalid", {31'd0, rvalid[0]}, 32'd0);
      chk("reset_rdata", rdata[0], 32'd0);
      chk("reset_rdcnt", {16'd0, rdcnt[0]}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // 1: fill a line, read it back, hold rreq past the pulse
      wr(13'h0040, 8'h11);
      wr(13'h0041, 8'h22);
      wr(13'h0042, 8'h33);
      wr(13'h0043, 8'h44);
      rd(0, 13'h0042, 3, d, lat, ex);
      chk("t1_data", d, 32'h44332211);
      chk("t1_lat", lat, 4);
      chk("t2_no_dup", ex, 0);
      chk("t1_rdcnt", {16'd0, rdcnt[0]}, 32'd1);
      chk("t1_wrcnt", {16'd0, wrcnt[0]}, 32'd4);

      // 2: re-request after one low cycle
      rd(0, 13'h0040, 0, d, lat, ex);
      chk("t2_data", d, 32'h44332211);
      chk("t2_lat", lat, 4);
      chk("t2_rdcnt", {16'd0, rdcnt[0]}, 32'd2);

      // 3: write during busy, then write on the capture edge
      fork
         rd(0, 13'h0040, 0, d, lat, ex);
         begin
            repeat (2) @(negedge clk);
            wr(13'h0041, 8'hAB);
         end
      join
      chk("t3_busy_wr", d, 32'h4433AB11);
      fork
         rd(0, 13'h0040, 0, d, lat, ex);
         begin
            repeat (4) @(negedge clk);
            wr(13'h0042, 8'hCD);
         end
      join
      chk("t3_merge", d, 32'h44CDAB11);

      // 4: top word of the address space
      wr(13'h1FFF, 8'h5A);
      rd(0, 13'h1FFC, 0, d, lat, ex);
      chk("t4_top", d, 32'h5A000000);
      chk("t4_wrcnt", {16'd0, wrcnt[0]}, 32'd7);

      // 5: asynchronous reset in the middle of a request
      rreq[0] = 1'b1; raddr[0] = 13'h0040;
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("t5_rvalid", {31'd0, rvalid[0]}, 32'd0);
      chk("t5_rdata", rdata[0], 32'd0);
      chk("t5_rdcnt", {16'd0, rdcnt[0]}, 32'd0);
      chk("t5_wrcnt", {16'd0, wrcnt[0]}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      raddr[0] = 13'h0040;
      wait_resp(0, d, lat);
      rreq[0] = 1'b0;
      @(negedge clk);
      chk("t5_data", d, 32'h44CDAB11);
      chk("t5_lat", lat, 4);
      chk("t5_rdcnt_after", {16'd0, rdcnt[0]}, 32'd1);

      // 6: latency 1, back-to-back requests
      for (int r = 0; r < 3; r++) begin
         rd(1, 13'h0040, 0, d, lat, ex);
         chk("t6_data", d, 32'h44CDAB11);
         chk("t6_lat", lat, 1);
      end
      chk("t6_rdcnt", {16'd0, rdcnt[1]}, 32'd3);

      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
